// File: rtl/alu_uart_sequencer.sv
// Sequences UART bytes into ALU operands/opcode, executes, and streams the
// ALU result back out through the UART transmitter, LSB byte first.
module alu_uart_sequencer #(
    parameter int BUS = 8,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     rx_data,
    input  logic           rx_done,
    input  logic           tx_done,
    input  logic [BUS-1:0] alu_result,
    output logic [BUS-1:0] alu_a,
    output logic [BUS-1:0] alu_b,
    output logic [OPW-1:0] alu_opcode,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    output logic           busy
);

    localparam int NBYTES = BUS / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [2:0] {
        RX_A,
        RX_B,
        RX_OP,
        EXEC,
        TX_START,
        TX_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BUS-1:0] a_q, a_d;
    logic [BUS-1:0] b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic [BUS-1:0] res_q, res_d;
    logic [7:0]     txd_q, txd_d;
    logic           txs_q, txs_d;
    logic           busy_q, busy_d;

    function automatic logic [7:0] pick_byte(input logic [BUS-1:0] w,
                                             input logic [CW-1:0]  idx);
        logic [7:0] r;
        r = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (idx == CW'(k)) r = w[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [BUS-1:0] put_byte(input logic [BUS-1:0] w,
                                                input logic [CW-1:0]  idx,
                                                input logic [7:0]     v);
        logic [BUS-1:0] r;
        r = w;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (idx == CW'(k)) r[8*k +: 8] = v;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            txd_q   <= '0;
            txs_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            txd_q   <= txd_d;
            txs_q   <= txs_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        txd_d   = txd_q;
        txs_d   = 1'b0;

        case (state_q)
            RX_A: begin
                if (rx_done) begin
                    a_d = put_byte(a_q, cnt_q, rx_data);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = RX_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RX_B: begin
                if (rx_done) begin
                    b_d = put_byte(b_q, cnt_q, rx_data);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = RX_OP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RX_OP: begin
                if (rx_done) begin
                    op_d    = rx_data[OPW-1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // tx_data/tx_start are registered, so the first byte is taken
                // straight from alu_result while it is being captured.
                res_d   = alu_result;
                cnt_d   = '0;
                txd_d   = pick_byte(alu_result, '0);
                txs_d   = 1'b1;
                state_d = TX_START;
            end
            TX_START: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = RX_A;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        txd_d   = pick_byte(res_q, cnt_q + 1'b1);
                        txs_d   = 1'b1;
                        state_d = TX_START;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_A;
            end
        endcase

        busy_d = (state_d == EXEC) || (state_d == TX_START) || (state_d == TX_WAIT);
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign tx_data    = txd_q;
    assign tx_start   = txs_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer: 8-bit vector table plus 16-bit and
// corner-case sequences, with a small reference ALU on the DUT's ALU port.
module tb_alu_uart_sequencer;

    logic clk;
    logic rst;

    logic [7:0]  rx_data8, tx_data8;
    logic        rx_done8, tx_done8, tx_start8, busy8;
    logic [7:0]  alu_res8, alu_a8, alu_b8;
    logic [5:0]  alu_op8;

    logic [7:0]  rx_data16, tx_data16;
    logic        rx_done16, tx_done16, tx_start16, busy16;
    logic [15:0] alu_res16, alu_a16, alu_b16;
    logic [5:0]  alu_op16;

    int checks;
    int failures;

    alu_uart_sequencer #(.BUS(8), .OPW(6)) dut8 (
        .clk(clk), .rst(rst), .rx_data(rx_data8), .rx_done(rx_done8),
        .tx_done(tx_done8), .alu_result(alu_res8), .alu_a(alu_a8),
        .alu_b(alu_b8), .alu_opcode(alu_op8), .tx_data(tx_data8),
        .tx_start(tx_start8), .busy(busy8)
    );

    alu_uart_sequencer #(.BUS(16), .OPW(6)) dut16 (
        .clk(clk), .rst(rst), .rx_data(rx_data16), .rx_done(rx_done16),
        .tx_done(tx_done16), .alu_result(alu_res16), .alu_a(alu_a16),
        .alu_b(alu_b16), .alu_opcode(alu_op16), .tx_data(tx_data16),
        .tx_start(tx_start16), .busy(busy16)
    );

    function automatic logic [7:0] ref_alu8(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            6'h24:   return a & b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] ref_alu16(input logic [15:0] a, input logic [15:0] b,
                                              input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h03:   return 16'($signed(a) >>> b);
            6'h02:   return a >> b;
            6'h24:   return a & b;
            6'h26:   return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_res8  = ref_alu8(alu_a8, alu_b8, alu_op8);
    assign alu_res16 = ref_alu16(alu_a16, alu_b16, alu_op16);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] v);
        rx_data8 = v;
        rx_done8 = 1'b1;
        step();
        rx_done8 = 1'b0;
    endtask

    task automatic send16(input logic [7:0] v);
        rx_data16 = v;
        rx_done16 = 1'b1;
        step();
        rx_done16 = 1'b0;
    endtask

    task automatic pulse_tx_done8();
        tx_done8 = 1'b1;
        step();
        tx_done8 = 1'b0;
    endtask

    // Full 8-bit operation: returns in TX_WAIT after checking latency and data.
    task automatic op8_to_wait(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                               input logic [7:0] exp, input string name);
        send8(a);
        send8(b);
        send8(op);
        check({name, " exec busy"}, 32'(busy8), 32'd1);
        check({name, " exec opcode"}, 32'(alu_op8), 32'(op & 8'h3F));
        check({name, " exec no start"}, 32'(tx_start8), 32'd0);
        step();
        check({name, " tx_start"}, 32'(tx_start8), 32'd1);
        check({name, " tx_data"}, 32'(tx_data8), 32'(exp));
        step();
        check({name, " start pulse width"}, 32'(tx_start8), 32'd0);
        check({name, " wait busy"}, 32'(busy8), 32'd1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[6];

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        rx_data8  = '0; rx_done8  = 1'b0; tx_done8  = 1'b0;
        rx_data16 = '0; rx_done16 = 1'b0; tx_done16 = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, "add"};
        vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE, "sub"};
        vecs[2] = '{8'h80, 8'h02, 8'h03, 8'hE0, "sra"};
        vecs[3] = '{8'h80, 8'h02, 8'h02, 8'h20, "srl"};
        vecs[4] = '{8'h05, 8'h03, 8'hE0, 8'h08, "op upper bits"};
        vecs[5] = '{8'h05, 8'h03, 8'h3F, 8'h00, "undefined op"};

        step();
        step();
        rst = 1'b0;
        check("reset alu_a", 32'(alu_a8), 32'd0);
        check("reset alu_b", 32'(alu_b8), 32'd0);
        check("reset opcode", 32'(alu_op8), 32'd0);
        check("reset tx_data", 32'(tx_data8), 32'd0);
        check("reset tx_start", 32'(tx_start8), 32'd0);
        check("reset busy", 32'(busy8), 32'd0);

        pulse_tx_done8();
        check("idle tx_done busy", 32'(busy8), 32'd0);
        check("idle tx_done start", 32'(tx_start8), 32'd0);

        for (int i = 0; i < 6; i++) begin
            op8_to_wait(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].name);
            step();
            pulse_tx_done8();
            check({vecs[i].name, " idle after done"}, 32'(busy8), 32'd0);
        end

        // rx bytes during TX_WAIT must be dropped
        op8_to_wait(8'h05, 8'h03, 8'h20, 8'h08, "drop");
        send8(8'hAA);
        send8(8'h55);
        send8(8'h3F);
        check("drop alu_a", 32'(alu_a8), 32'h05);
        check("drop alu_b", 32'(alu_b8), 32'h03);
        check("drop opcode", 32'(alu_op8), 32'h20);
        check("drop no start", 32'(tx_start8), 32'd0);
        check("drop busy", 32'(busy8), 32'd1);
        pulse_tx_done8();
        check("drop idle", 32'(busy8), 32'd0);
        op8_to_wait(8'h0F, 8'hF0, 8'h24, 8'h00, "and");
        pulse_tx_done8();
        check("and idle", 32'(busy8), 32'd0);

        // tx_done coincident with tx_start is ignored
        send8(8'h05);
        send8(8'h03);
        send8(8'h20);
        tx_done8 = 1'b1;
        step();
        tx_done8 = 1'b0;
        check("coincident start", 32'(tx_start8), 32'd1);
        step();
        step();
        check("coincident still busy", 32'(busy8), 32'd1);
        check("coincident no restart", 32'(tx_start8), 32'd0);
        pulse_tx_done8();
        check("coincident idle", 32'(busy8), 32'd0);

        // 16-bit two-byte result
        send16(8'h34);
        send16(8'h12);
        send16(8'h01);
        send16(8'h00);
        send16(8'h20);
        check("w16 alu_a", 32'(alu_a16), 32'h1234);
        check("w16 alu_b", 32'(alu_b16), 32'h0001);
        check("w16 busy", 32'(busy16), 32'd1);
        step();
        check("w16 start0", 32'(tx_start16), 32'd1);
        check("w16 byte0", 32'(tx_data16), 32'h35);
        step();
        step();
        check("w16 wait0", 32'(tx_start16), 32'd0);
        check("w16 hold data", 32'(tx_data16), 32'h35);
        tx_done16 = 1'b1;
        step();
        tx_done16 = 1'b0;
        check("w16 start1", 32'(tx_start16), 32'd1);
        check("w16 byte1", 32'(tx_data16), 32'h12);
        step();
        check("w16 wait1", 32'(tx_start16), 32'd0);
        check("w16 busy1", 32'(busy16), 32'd1);
        tx_done16 = 1'b1;
        step();
        tx_done16 = 1'b0;
        check("w16 idle", 32'(busy16), 32'd0);

        // reset in TX_WAIT
        op8_to_wait(8'h05, 8'h03, 8'h20, 8'h08, "pre-reset");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid reset alu_a", 32'(alu_a8), 32'd0);
        check("mid reset alu_b", 32'(alu_b8), 32'd0);
        check("mid reset opcode", 32'(alu_op8), 32'd0);
        check("mid reset tx_data", 32'(tx_data8), 32'd0);
        check("mid reset tx_start", 32'(tx_start8), 32'd0);
        check("mid reset busy", 32'(busy8), 32'd0);
        pulse_tx_done8();
        check("late tx_done busy", 32'(busy8), 32'd0);
        check("late tx_done start", 32'(tx_start8), 32'd0);
        op8_to_wait(8'h02, 8'h02, 8'h26, 8'h00, "xor");
        pulse_tx_done8();
        check("xor idle", 32'(busy8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
